// File: rtl/jk_bank_writer.sv
// Write-side controller for an external bank of JK flip-flops: drives the minimal
// excitation for one cycle, waits for the bank to settle, verifies q and retries on mismatch.
module jk_bank_writer #(
    parameter int WIDTH      = 8,
    parameter int USE_TOGGLE = 0,
    parameter int SETTLE_CYC = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       retry_cnt
);

    localparam logic [3:0] LP_SETTLE    = 4'(SETTLE_CYC);
    localparam logic [2:0] LP_MAX_RETRY = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_j, r_k, r_target;
    logic [WIDTH-1:0] w_j_next, w_k_next, w_target_next;
    logic             r_ready, r_busy, r_done, r_err;
    logic             w_done_next, w_err_next;
    logic [2:0]       r_retry, w_retry_next;
    logic [3:0]       r_settle, w_settle_next;

    // Excitation is computed from the live q_fb: in IDLE against the incoming word,
    // in CHECK against the stored target (that is the q recapture for a retry).
    logic [WIDTH-1:0] w_exc_t, w_exc_j, w_exc_k;
    assign w_exc_t = (r_state == ST_IDLE) ? req_data : r_target;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_exc
            if (USE_TOGGLE != 0) begin : g_tog
                assign w_exc_j[gi] = q_fb[gi] ^ w_exc_t[gi];
                assign w_exc_k[gi] = q_fb[gi] ^ w_exc_t[gi];
            end else begin : g_sr
                assign w_exc_j[gi] = ~q_fb[gi] &  w_exc_t[gi];
                assign w_exc_k[gi] =  q_fb[gi] & ~w_exc_t[gi];
            end
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_j_next      = '0;
        w_k_next      = '0;
        w_target_next = r_target;
        w_retry_next  = r_retry;
        w_settle_next = r_settle;
        w_done_next   = 1'b0;
        w_err_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_ready) begin
                    w_state_next  = ST_DRIVE;
                    w_target_next = req_data;
                    w_retry_next  = 3'd0;
                    w_j_next      = w_exc_j;
                    w_k_next      = w_exc_k;
                end
            end
            ST_DRIVE: begin
                w_state_next  = ST_SETTLE;
                w_settle_next = LP_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle <= 4'd1) begin
                    w_state_next = ST_CHECK;
                end else begin
                    w_settle_next = r_settle - 4'd1;
                end
            end
            ST_CHECK: begin
                if (q_fb == r_target) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else if (r_retry < LP_MAX_RETRY) begin
                    w_state_next = ST_DRIVE;
                    w_retry_next = r_retry + 3'd1;
                    w_j_next     = w_exc_j;
                    w_k_next     = w_exc_k;
                end else begin
                    w_state_next = ST_IDLE;
                    w_err_next   = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Async reset clears j/k at once so an abandoned request never keeps driving the bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_j      <= '0;
            r_k      <= '0;
            r_target <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_retry  <= 3'd0;
            r_settle <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_j      <= w_j_next;
            r_k      <= w_k_next;
            r_target <= w_target_next;
            r_ready  <= (w_state_next == ST_IDLE);
            r_busy   <= (w_state_next != ST_IDLE);
            r_done   <= w_done_next;
            r_err    <= w_err_next;
            r_retry  <= w_retry_next;
            r_settle <= w_settle_next;
        end
    end

    assign j         = r_j;
    assign k         = r_k;
    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign retry_cnt = r_retry;

endmodule

// File: tb/tb_jk_bank_writer.sv
// Directed bench: two writers (set/reset and toggle excitation) each driving a behavioural JK bank.
module tb_jk_bank_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       req_valid;
    logic [7:0] req_data;
    logic       ld_en;
    logic [7:0] ld_val;
    logic       frc_en;
    logic [7:0] frc_val;

    logic       rv_s, rv_t, rdy_s, rdy_t, busy_s, busy_t, done_s, done_t, err_s, err_t;
    logic [7:0] j_s, k_s, j_t, k_t, bank_s, bank_t, qfb_s, qfb_t;
    logic [2:0] rc_s, rc_t;

    logic       o_ready, o_busy, o_done, o_err;
    logic [7:0] o_j, o_k, o_bank;
    logic [2:0] o_retry;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign rv_s  = req_valid & ~sel;
    assign rv_t  = req_valid &  sel;
    assign qfb_s = frc_en ? frc_val : bank_s;
    assign qfb_t = frc_en ? frc_val : bank_t;

    assign o_ready = sel ? rdy_t  : rdy_s;
    assign o_busy  = sel ? busy_t : busy_s;
    assign o_done  = sel ? done_t : done_s;
    assign o_err   = sel ? err_t  : err_s;
    assign o_j     = sel ? j_t    : j_s;
    assign o_k     = sel ? k_t    : k_s;
    assign o_bank  = sel ? bank_t : bank_s;
    assign o_retry = sel ? rc_t   : rc_s;

    // JK bank model: q+ = J&~q | ~K&q
    always @(posedge clk) begin
        if (ld_en) begin
            bank_s <= ld_val;
            bank_t <= ld_val;
        end else begin
            bank_s <= (j_s & ~bank_s) | (~k_s & bank_s);
            bank_t <= (j_t & ~bank_t) | (~k_t & bank_t);
        end
    end

    jk_bank_writer #(.WIDTH(8), .USE_TOGGLE(0), .SETTLE_CYC(1), .MAX_RETRY(3)) dut_s (
        .clock(clk), .reset(rst), .req_valid(rv_s), .req_ready(rdy_s), .req_data(req_data),
        .q_fb(qfb_s), .j(j_s), .k(k_s), .busy(busy_s), .done(done_s), .err(err_s),
        .retry_cnt(rc_s)
    );

    jk_bank_writer #(.WIDTH(8), .USE_TOGGLE(1), .SETTLE_CYC(1), .MAX_RETRY(3)) dut_t (
        .clock(clk), .reset(rst), .req_valid(rv_t), .req_ready(rdy_t), .req_data(req_data),
        .q_fb(qfb_t), .j(j_t), .k(k_t), .busy(busy_t), .done(done_t), .err(err_t),
        .retry_cnt(rc_t)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input logic [7:0] v);
        ld_en = 1'b1; ld_val = v;
        tick();
        ld_en = 1'b0;
    endtask

    // Transfer edge is cycle 0; returns j/k seen in cycle 1 and the cycle of done/err.
    task automatic send(input logic [7:0] d, output logic [7:0] j1, output logic [7:0] k1,
                        output int fin, output int n_drv, output int n_bad,
                        output logic saw_done, output logic saw_err);
        req_valid = 1'b1; req_data = d;
        tick();
        req_valid = 1'b0;
        j1 = o_j; k1 = o_k;
        fin = -1; n_drv = 0; n_bad = 0; saw_done = 1'b0; saw_err = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (o_j != 8'h00 || o_k != 8'h00) begin
                n_drv++;
                if (o_j != j1 || o_k != k1) n_bad++;
            end
            if (o_done || o_err) begin
                fin = c; saw_done = o_done; saw_err = o_err;
                break;
            end
            tick();
        end
        chk("completes_in_budget", 32'(fin > 0), 32'd1);
        $display("req 0x%02h: j1=0x%02h k1=0x%02h fin=%0d drv=%0d done=%0b err=%0b retry=%0d bank=0x%02h",
                 d, j1, k1, fin, n_drv, saw_done, saw_err, o_retry, o_bank);
    endtask

    logic [7:0] j1, k1;
    int         fin, n_drv, n_bad, n_pulse;
    logic       sd, se;

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_data = 8'h00;
        ld_en = 1'b0; ld_val = 8'h00; frc_en = 1'b0; frc_val = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_j", 32'(o_j), 32'h00);
        chk("rst_k", 32'(o_k), 32'h00);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done_err", 32'({o_done, o_err}), 32'd0);
        chk("rst_retry", 32'(o_retry), 32'd0);
        rst = 1'b0;

        // Set/reset excitation
        load_bank(8'h0F);
        send(8'hF0, j1, k1, fin, n_drv, n_bad, sd, se);
        chk("sr_j", 32'(j1), 32'hF0);
        chk("sr_k", 32'(k1), 32'h0F);
        chk("sr_latency", 32'(fin), 32'd4);
        chk("sr_done_err", 32'({sd, se}), 32'b10);
        chk("sr_retry", 32'(o_retry), 32'd0);
        chk("sr_bank", 32'(o_bank), 32'hF0);
        chk("sr_ready_with_done", 32'(o_ready), 32'd1);
        tick();
        chk("sr_done_one_cycle", 32'(o_done), 32'd0);

        // Toggle excitation
        sel = 1'b1;
        load_bank(8'h0F);
        send(8'hF0, j1, k1, fin, n_drv, n_bad, sd, se);
        chk("tog_j", 32'(j1), 32'hFF);
        chk("tog_k", 32'(k1), 32'hFF);
        chk("tog_latency", 32'(fin), 32'd4);
        chk("tog_done", 32'(sd), 32'd1);
        chk("tog_bank", 32'(o_bank), 32'hF0);
        sel = 1'b0;
        tick();

        // Stuck bit: first try + 3 retries, err at cycle 13
        frc_en = 1'b1; frc_val = 8'h00;
        send(8'h01, j1, k1, fin, n_drv, n_bad, sd, se);
        chk("stuck_j", 32'(j1), 32'h01);
        chk("stuck_k", 32'(k1), 32'h00);
        chk("stuck_drives", 32'(n_drv), 32'd4);
        chk("stuck_drive_pattern", 32'(n_bad), 32'd0);
        chk("stuck_err_cycle", 32'(fin), 32'd13);
        chk("stuck_done_err", 32'({sd, se}), 32'b01);
        chk("stuck_retry", 32'(o_retry), 32'd3);
        tick();
        chk("stuck_err_one_cycle", 32'(o_err), 32'd0);
        chk("stuck_retry_held", 32'(o_retry), 32'd3);
        frc_en = 1'b0;

        // No-change request with a second request held during busy
        load_bank(8'h5A);
        req_valid = 1'b1; req_data = 8'h5A;
        tick();
        req_data = 8'h33;
        chk("same_j", 32'(o_j), 32'h00);
        chk("same_k", 32'(o_k), 32'h00);
        chk("same_retry_cleared", 32'(o_retry), 32'd0);
        fin = -1;
        for (int c = 1; c <= 20; c++) begin
            if (o_ready) begin
                fin = c;
                break;
            end
            tick();
        end
        chk("same_ready_cycle", 32'(fin), 32'd4);
        chk("same_done", 32'(o_done), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("queued_busy", 32'(o_busy), 32'd1);
        chk("queued_j", 32'(o_j), 32'h21);
        chk("queued_k", 32'(o_k), 32'h48);
        for (int c = 2; c <= 20 && !o_done; c++) tick();
        chk("queued_done", 32'(o_done), 32'd1);
        chk("queued_bank", 32'(o_bank), 32'h33);
        $display("busy test: held request accepted after done, bank=0x%02h", o_bank);
        tick();

        // Reset while DRIVE is active: j/k clear without a clock edge
        load_bank(8'h00);
        req_valid = 1'b1; req_data = 8'hFF;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_j", 32'(o_j), 32'hFF);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_j", 32'(o_j), 32'h00);
        chk("async_rst_k", 32'(o_k), 32'h00);
        tick();
        rst = 1'b0;

        // Reset during SETTLE
        req_valid = 1'b1; req_data = 8'hFF;
        tick();
        req_valid = 1'b0;
        tick();
        chk("settle_busy", 32'(o_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("settle_rst_ready", 32'(o_ready), 32'd1);
        chk("settle_rst_busy", 32'(o_busy), 32'd0);
        tick();
        rst = 1'b0;
        n_pulse = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_done || o_err) n_pulse++;
            tick();
        end
        chk("settle_rst_no_pulse", 32'(n_pulse), 32'd0);
        $display("reset in settle: bank=0x%02h pulses=%0d", o_bank, n_pulse);

        send(8'h3C, j1, k1, fin, n_drv, n_bad, sd, se);
        chk("after_rst_j", 32'(j1), 32'h00);
        chk("after_rst_k", 32'(k1), 32'hC3);
        chk("after_rst_latency", 32'(fin), 32'd4);
        chk("after_rst_done", 32'(sd), 32'd1);
        chk("after_rst_bank", 32'(o_bank), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
